// File: rtl/current_pi_loop.sv
// rtl/current_pi_loop.sv - PI motor-current regulator with anti-windup, slew limit, clamp and open-loop bypass
// Four-state loop IDLE/WAIT/COMPUTE/UPDATE, one regulator update per DIV-cycle tick.
module current_pi_loop #(
  parameter int W        = 12,
  parameter int ACC_W    = 20,
  parameter int KP_SHIFT = 0,
  parameter int KI_SHIFT = 4,
  parameter int DIV      = 32,
  parameter int DEADBAND = 3,
  parameter int SLEW_MAX = 256
) (
  input  logic         c20k,
  input  logic         reset,
  input  logic         enable,
  input  logic         mode,
  input  logic [W-1:0] assist_req,
  input  logic [W-1:0] phase_v,
  input  logic         phase_v_valid,
  output logic [W-1:0] motor_signal,
  output logic         sat_hi,
  output logic         sat_lo,
  output logic         update_strobe,
  output logic [1:0]   loop_state
);

  localparam int EW = W + 1;
  localparam int UW = ACC_W + 1;
  localparam int DW = ACC_W + 2;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic signed [ACC_W:0] ACC_HI = (ACC_W+1)'((1 <<< (ACC_W-1)) - 1);
  localparam logic signed [ACC_W:0] ACC_LO = ~ACC_HI;
  localparam logic signed [DW-1:0]  SLEW_P = DW'(SLEW_MAX);
  localparam logic signed [DW-1:0]  SLEW_N = -SLEW_P;
  localparam logic signed [DW-1:0]  MAX_P  = DW'((1 << W) - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    COMPUTE = 2'd2,
    UPDATE  = 2'd3
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    tick;
  logic                    active;
  logic [W-1:0]            sample;
  logic                    fresh;
  logic signed [ACC_W-1:0] integ;
  logic signed [ACC_W-1:0] integ_pend;
  logic signed [EW-1:0]    err_r;
  logic signed [UW-1:0]    u_r;

  logic signed [EW-1:0]    err_c;
  logic signed [ACC_W:0]   acc_sum;
  logic signed [ACC_W-1:0] integ_c;
  logic signed [UW-1:0]    p_term;
  logic signed [UW-1:0]    i_term;
  logic signed [UW-1:0]    u_c;

  logic signed [DW-1:0]    motor_ext;
  logic signed [DW-1:0]    d_raw;
  logic signed [DW-1:0]    d_clip;
  logic signed [DW-1:0]    next_raw;
  logic                    clamp_hi;
  logic                    clamp_lo;
  logic [W-1:0]            motor_next;
  logic                    hold_integ;

  assign tick       = (cnt == CW'(DIV - 1));
  assign active     = enable && (assist_req > W'(DEADBAND));
  assign loop_state = state;

  // Error, saturating integrator and PI sum evaluated during COMPUTE.
  always_comb begin
    err_c   = $signed({1'b0, assist_req}) - $signed({1'b0, sample});
    acc_sum = $signed({integ[ACC_W-1], integ})
            + $signed({{(ACC_W+1-EW){err_c[EW-1]}}, err_c});
    if (acc_sum > ACC_HI)
      integ_c = ACC_HI[ACC_W-1:0];
    else if (acc_sum < ACC_LO)
      integ_c = ACC_LO[ACC_W-1:0];
    else
      integ_c = acc_sum[ACC_W-1:0];
    p_term = $signed({{(UW-EW){err_c[EW-1]}}, err_c}) >>> KP_SHIFT;
    i_term = $signed({integ_c[ACC_W-1], integ_c}) >>> KI_SHIFT;
    u_c    = p_term + i_term;
    if (mode) begin
      u_c     = $signed({{(UW-W){1'b0}}, assist_req});
      integ_c = '0;
    end
  end

  // Slew limit, output clamp and the windup hold applied during UPDATE.
  always_comb begin
    motor_ext = $signed({{(DW-W){1'b0}}, motor_signal});
    d_raw     = $signed({u_r[UW-1], u_r}) - motor_ext;
    if (d_raw > SLEW_P)
      d_clip = SLEW_P;
    else if (d_raw < SLEW_N)
      d_clip = SLEW_N;
    else
      d_clip = d_raw;
    next_raw   = motor_ext + d_clip;
    clamp_hi   = (next_raw > MAX_P);
    clamp_lo   = next_raw[DW-1];
    motor_next = clamp_hi ? '1 : (clamp_lo ? '0 : next_raw[W-1:0]);
    hold_integ = (clamp_hi && !err_r[EW-1] && (err_r != '0))
              || (clamp_lo && err_r[EW-1]);
  end

  always_ff @(posedge c20k or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      sample        <= '0;
      fresh         <= 1'b0;
      integ         <= '0;
      integ_pend    <= '0;
      err_r         <= '0;
      u_r           <= '0;
      motor_signal  <= '0;
      sat_hi        <= 1'b0;
      sat_lo        <= 1'b0;
      update_strobe <= 1'b0;
    end else begin
      cnt           <= tick ? '0 : cnt + CW'(1);
      update_strobe <= 1'b0;

      // A sample arriving on the consuming edge replaces the consumed one.
      if (phase_v_valid) begin
        sample <= phase_v;
        fresh  <= 1'b1;
      end else if (state == WAIT && active && tick && (fresh || mode)) begin
        fresh  <= 1'b0;
      end

      if (!active) begin
        state        <= IDLE;
        motor_signal <= '0;
        integ        <= '0;
        sat_hi       <= 1'b0;
        sat_lo       <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= WAIT;
          WAIT: begin
            if (tick && (fresh || mode))
              state <= COMPUTE;
          end
          COMPUTE: begin
            err_r      <= err_c;
            u_r        <= u_c;
            integ_pend <= integ_c;
            state      <= UPDATE;
          end
          UPDATE: begin
            motor_signal  <= motor_next;
            sat_hi        <= clamp_hi;
            sat_lo        <= clamp_lo;
            update_strobe <= 1'b1;
            if (!hold_integ)
              integ <= integ_pend;
            state <= WAIT;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_current_pi_loop.sv
// tb/tb_current_pi_loop.sv - randomized self-checking bench for current_pi_loop against an integer model
module tb_current_pi_loop;

  localparam int W        = 12;
  localparam int ACC_W    = 20;
  localparam int KP_SHIFT = 0;
  localparam int KI_SHIFT = 4;
  localparam int DIV      = 32;
  localparam int DEADBAND = 3;
  localparam int SLEW_MAX = 256;
  localparam int MAXV     = (1 << W) - 1;
  localparam int ACC_MAX  = (1 << (ACC_W - 1)) - 1;
  localparam int ACC_MIN  = -(1 << (ACC_W - 1));
  localparam int PULSE_AT = 10;

  logic         c20k = 1'b0;
  logic         reset;
  logic         enable;
  logic         mode;
  logic [W-1:0] assist_req;
  logic [W-1:0] phase_v;
  logic         phase_v_valid;
  logic [W-1:0] motor_signal;
  logic         sat_hi;
  logic         sat_lo;
  logic         update_strobe;
  logic [1:0]   loop_state;

  always #5 c20k = ~c20k;

  current_pi_loop #(
    .W(W), .ACC_W(ACC_W), .KP_SHIFT(KP_SHIFT), .KI_SHIFT(KI_SHIFT),
    .DIV(DIV), .DEADBAND(DEADBAND), .SLEW_MAX(SLEW_MAX)
  ) dut (
    .c20k(c20k), .reset(reset), .enable(enable), .mode(mode),
    .assist_req(assist_req), .phase_v(phase_v), .phase_v_valid(phase_v_valid),
    .motor_signal(motor_signal), .sat_hi(sat_hi), .sat_lo(sat_lo),
    .update_strobe(update_strobe), .loop_state(loop_state)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: phase 0 idle, 1 waiting, 2 computing, 3 updating.
  int m_cnt, m_phase, m_sample, m_fresh, m_integ, m_motor;
  int m_hi, m_lo, m_strobe, m_err, m_u, m_in;
  bit pulse_en;
  bit extra_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_phase = 0; m_sample = 0; m_fresh = 0; m_integ = 0; m_motor = 0;
    m_hi = 0; m_lo = 0; m_strobe = 0; m_err = 0; m_u = 0; m_in = 0;
  endtask

  task automatic model_step();
    int  a       = int'(assist_req);
    bit  act     = enable && (a > DEADBAND);
    bit  tick    = (m_cnt == DIV - 1);
    bit  enter   = 1'b0;
    int  n_phase = m_phase;
    int  n_motor = m_motor;
    int  n_integ = m_integ;
    int  n_hi    = m_hi;
    int  n_lo    = m_lo;
    int  n_err   = m_err;
    int  n_u     = m_u;
    int  n_in    = m_in;
    int  d, v;
    if (!act) begin
      n_phase = 0; n_motor = 0; n_integ = 0; n_hi = 0; n_lo = 0;
    end else begin
      case (m_phase)
        0: n_phase = 1;
        1: if (tick && (m_fresh != 0 || mode)) begin n_phase = 2; enter = 1'b1; end
        2: begin
          n_err = a - m_sample;
          n_in  = m_integ + n_err;
          if (n_in > ACC_MAX) n_in = ACC_MAX;
          if (n_in < ACC_MIN) n_in = ACC_MIN;
          n_u = (n_err >>> KP_SHIFT) + (n_in >>> KI_SHIFT);
          if (mode) begin n_u = a; n_in = 0; end
          n_phase = 3;
        end
        default: begin
          d = m_u - m_motor;
          if (d > SLEW_MAX) d = SLEW_MAX;
          if (d < -SLEW_MAX) d = -SLEW_MAX;
          v = m_motor + d;
          n_hi = (v > MAXV) ? 1 : 0;
          n_lo = (v < 0) ? 1 : 0;
          n_motor = (v > MAXV) ? MAXV : ((v < 0) ? 0 : v);
          if (!((n_hi != 0 && m_err > 0) || (n_lo != 0 && m_err < 0))) n_integ = m_in;
          n_phase = 1;
        end
      endcase
    end
    m_strobe = (act && m_phase == 3) ? 1 : 0;
    if (phase_v_valid) begin m_sample = int'(phase_v); m_fresh = 1; end
    else if (enter) m_fresh = 0;
    m_cnt = tick ? 0 : m_cnt + 1;
    m_phase = n_phase; m_motor = n_motor; m_integ = n_integ; m_hi = n_hi; m_lo = n_lo;
    m_err = n_err; m_u = n_u; m_in = n_in;
  endtask

  task automatic cycle();
    phase_v_valid = (pulse_en && m_cnt == PULSE_AT) || extra_valid;
    model_step();
    @(posedge c20k);
    #1;
    check("motor", motor_signal, m_motor);
    check("flags", {loop_state, update_strobe, sat_hi, sat_lo},
          (m_phase << 3) | (m_strobe << 2) | (m_hi << 1) | m_lo);
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!update_strobe && n < 4 * DIV);
    check(tag, update_strobe, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge c20k);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int cnt_s;
    bit last;
    reset = 1'b1; enable = 1'b0; mode = 1'b0; assist_req = '0; phase_v = '0;
    phase_v_valid = 1'b0; pulse_en = 1'b0; extra_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge c20k);
    #1;
    check("rst_motor", motor_signal, 0);
    check("rst_flags", {loop_state, update_strobe, sat_hi, sat_lo}, 0);
    reset = 1'b0;

    // Open-loop bypass: slew-limited step toward assist_req, no samples needed.
    enable = 1'b1; mode = 1'b1; assist_req = 12'd300;
    wait_strobe("ol_s1");
    check("ol_256", motor_signal, 256);
    wait_strobe("ol_s2");
    check("ol_300", motor_signal, 300);

    // Asynchronous reset landing in UPDATE.
    assist_req = 12'd2000;
    repeat (7) wait_strobe("ol_ramp");
    check("ol_2000", motor_signal, 2000);
    n = 0;
    do begin cycle(); n++; end while (loop_state != 2'd3 && n < 4 * DIV);
    check("reach_update", loop_state, 3);
    check("pre_rst_motor", motor_signal, 2000);
    #2;
    reset = 1'b1;
    #1;
    check("async_motor", motor_signal, 0);
    check("async_flags", {loop_state, update_strobe, sat_hi, sat_lo}, 0);
    model_reset();
    @(posedge c20k);
    #1;
    reset = 1'b0;

    // Deadband drop-out and its boundary.
    assist_req = 12'd1500;
    repeat (7) wait_strobe("ol_1500_ramp");
    check("ol_1500", motor_signal, 1500);
    assist_req = 12'd3;
    cycle();
    check("db_motor", motor_signal, 0);
    check("db_idle", loop_state, 0);
    cycle();
    check("db_stay", loop_state, 0);
    assist_req = 12'd4;
    cycle();
    check("db4_wait", loop_state, 1);

    // Closed-loop ramp into saturation, windup hold, then recovery.
    do_reset();
    mode = 1'b0; assist_req = 12'd1000; phase_v = '0; pulse_en = 1'b1;
    wait_strobe("cl_s1"); check("cl_256", motor_signal, 256);
    wait_strobe("cl_s2"); check("cl_512", motor_signal, 512);
    wait_strobe("cl_s3"); check("cl_768", motor_signal, 768);
    repeat (70) wait_strobe("cl_run");
    check("cl_sat_hi", sat_hi, 1);
    check("cl_4095", motor_signal, 4095);
    repeat (10) wait_strobe("cl_hold");
    check("integ_hold", dut.integ, 49000);
    check("hold_sat", sat_hi, 1);
    phase_v = 12'd4095;
    wait_strobe("rec");
    check("rec_motor", motor_signal, 3839);
    check("rec_sat", sat_hi, 0);
    check("rec_integ", dut.integ, 45905);

    // Stale sample: no updates; then a sample on the consuming edge keeps fresh set.
    pulse_en = 1'b0;
    cnt_s = 0;
    repeat (3 * DIV) begin cycle(); if (update_strobe) cnt_s++; end
    check("stale_none", cnt_s, 0);
    check("stale_hold", motor_signal, 3839);
    for (int i = 0; i < 2 * DIV; i++) begin
      extra_valid = (m_cnt == PULSE_AT) || (m_cnt == DIV - 1);
      last = (m_cnt == DIV - 1);
      cycle();
      if (last) break;
    end
    extra_valid = 1'b0;
    check("coinc_compute", loop_state, 2);
    cnt_s = 0;
    repeat (2 * DIV) begin cycle(); if (update_strobe) cnt_s++; end
    check("coinc_two", cnt_s, 2);

    // Randomized traffic against the model.
    do_reset();
    for (int p = 0; p < 400; p++) begin
      if ($urandom_range(0, 2) == 0) begin
        assist_req = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 6)) : W'($urandom_range(0, MAXV));
        mode       = ($urandom_range(0, 9) == 0);
        enable     = ($urandom_range(0, 19) != 0);
      end
      repeat (DIV) begin
        extra_valid = ($urandom_range(0, 11) == 0);
        if (extra_valid) phase_v = W'($urandom_range(0, MAXV));
        cycle();
      end
    end
    extra_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
